// File: rtl/axi_lite_rr_master.sv
// Two-requester round-robin front end for a single AXI4-Lite master port.
// One transaction is in flight at a time. The winner's payload is captured
// at grant and replayed onto the AXI channels. Completion is reported with a
// one-cycle REQ_DONE pulse plus the shared REQ_RESP / REQ_RDATA registers.
module axi_lite_rr_master (
   input  logic        ACLK,
   input  logic        ARESET,
   input  logic [1:0]  REQ_VALID,
   input  logic [1:0]  REQ_WRITE,
   input  logic [7:0]  REQ_ADDR,
   input  logic [63:0] REQ_WDATA,
   output logic [1:0]  REQ_DONE,
   output logic [31:0] REQ_RDATA,
   output logic [1:0]  REQ_RESP,
   output logic [3:0]  M_AWADDR,
   output logic        M_AWVALID,
   input  logic        M_AWREADY,
   output logic [31:0] M_WDATA,
   output logic        M_WVALID,
   input  logic        M_WREADY,
   input  logic [1:0]  M_BRESP,
   input  logic        M_BVALID,
   output logic        M_BREADY,
   output logic [3:0]  M_ARADDR,
   output logic        M_ARVALID,
   input  logic        M_ARREADY,
   input  logic [31:0] M_RDATA,
   input  logic        M_RVALID,
   output logic        M_RREADY,
   input  logic [1:0]  M_RRESP
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_ADDR = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_ADDR = 3'd3;
   localparam logic [2:0] RD_DATA = 3'd4;

   logic [2:0]  state;
   logic        last_ptr;
   logic        grant_idx;
   logic [3:0]  lat_addr;
   logic [31:0] lat_wdata;
   logic        aw_done;
   logic        w_done;
   logic [1:0]  eligible;
   logic        winner;
   logic        aw_hs;
   logic        w_hs;
   logic [1:0]  grant_onehot;

   // A requester whose REQ_DONE is high this cycle is still holding REQ_VALID
   // for one more cycle, so it is masked out; on a tie the one not served last wins.
   always_comb begin
      eligible = REQ_VALID & ~REQ_DONE;
      winner   = 1'b0;
      if (eligible == 2'b11) begin
         winner = ~last_ptr;
      end else begin
         winner = eligible[1];
      end
   end

   // Channel handshake signals decode directly from the FSM state and the
   // per-channel "already accepted" flags, so AW and W drop independently.
   assign M_AWVALID    = (state == WR_ADDR) && !aw_done;
   assign M_WVALID     = (state == WR_ADDR) && !w_done;
   assign M_BREADY     = (state == WR_RESP);
   assign M_ARVALID    = (state == RD_ADDR);
   assign M_RREADY     = (state == RD_DATA);
   assign M_AWADDR     = lat_addr;
   assign M_ARADDR     = lat_addr;
   assign M_WDATA      = lat_wdata;
   assign aw_hs        = M_AWVALID && M_AWREADY;
   assign w_hs         = M_WVALID && M_WREADY;
   assign grant_onehot = grant_idx ? 2'b10 : 2'b01;

   // Transaction FSM: grant and capture in IDLE, walk the AXI channels, then
   // report completion and advance the round-robin pointer.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state     <= IDLE;
         last_ptr  <= 1'b1;
         grant_idx <= 1'b0;
         lat_addr  <= 4'h0;
         lat_wdata <= 32'h0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
         REQ_DONE  <= 2'b00;
         REQ_RDATA <= 32'h0;
         REQ_RESP  <= 2'b00;
      end else begin
         REQ_DONE <= 2'b00;
         case (state)
            IDLE: begin
               if (eligible != 2'b00) begin
                  grant_idx <= winner;
                  lat_addr  <= winner ? REQ_ADDR[7:4] : REQ_ADDR[3:0];
                  lat_wdata <= winner ? REQ_WDATA[63:32] : REQ_WDATA[31:0];
                  aw_done   <= 1'b0;
                  w_done    <= 1'b0;
                  state     <= REQ_WRITE[winner] ? WR_ADDR : RD_ADDR;
               end
            end
            WR_ADDR: begin
               if (aw_hs) begin
                  aw_done <= 1'b1;
               end
               if (w_hs) begin
                  w_done <= 1'b1;
               end
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  state <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (M_BVALID) begin
                  REQ_RESP <= M_BRESP;
                  REQ_DONE <= grant_onehot;
                  last_ptr <= grant_idx;
                  state    <= IDLE;
               end
            end
            RD_ADDR: begin
               if (M_ARREADY) begin
                  state <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (M_RVALID) begin
                  REQ_RDATA <= M_RDATA;
                  REQ_RESP  <= M_RRESP;
                  REQ_DONE  <= grant_onehot;
                  last_ptr  <= grant_idx;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/axi_lite_rr_master.md
AXI_LITE_RR_MASTER -- requirements
Module: axi_lite_rr_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
  ACLK  input  1  clock; all state updates on rising edge
  ARESET  input  1  synchronous, active-high reset
  REQ_VALID  input  2  per-requester request; held until matching REQ_DONE bit
  REQ_WRITE  input  2  per-requester 1=write, 0=read
  REQ_ADDR  input  8  requester i address at [4i+3:4i]
  REQ_WDATA  input  64  requester i write data at [32i+31:32i]
  REQ_DONE  output  2  one-cycle completion pulse to granted requester
  REQ_RDATA  output  32  last completed read data, shared
  REQ_RESP  output  2  response of last completed transaction, shared
  M_AWADDR  output  4  AXI4-Lite write address
  M_AWVALID  output  1  write address valid
  M_AWREADY  input  1  write address ready
  M_WDATA  output  32  write data
  M_WVALID  output  1  write data valid
  M_WREADY  input  1  write data ready
  M_BRESP  input  2  write response
  M_BVALID  input  1  write response valid
  M_BREADY  output  1  write response ready
  M_ARADDR  output  4  read address
  M_ARVALID  output  1  read address valid
  M_ARREADY  input  1  read address ready
  M_RDATA  input  32  read data
  M_RVALID  input  1  read data valid
  M_RREADY  output  1  read data ready
  M_RRESP  input  2  read response

Function
REQ-002 FSM states SHALL be IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA; at most one transaction is outstanding.
REQ-003 In IDLE the block SHALL grant one requester with REQ_VALID=1 by round-robin: the requester not served last wins ties. The last-grant pointer resets to 1, so requester 0 wins the first tie.
REQ-004 On grant, the block SHALL latch the winner's index, REQ_WRITE, address and wdata, then go to WR_ADDR (write) or RD_ADDR (read).
REQ-005 Payload and REQ_VALID SHALL be sampled only at grant; deassertion after grant SHALL NOT abort the transaction.
REQ-006 In WR_ADDR, M_AWVALID and M_WVALID SHALL assert together.
  Each SHALL drop the cycle after its own handshake (VALID&READY), independently.
  The FSM SHALL move to WR_RESP once both handshakes are done, in the same or different cycles.
REQ-007 In WR_RESP, M_BREADY=1. On M_BVALID the block SHALL set REQ_RESP=M_BRESP, pulse REQ_DONE[grant] next cycle and return to IDLE.
REQ-008 In RD_ADDR, M_ARVALID=1 until M_ARREADY, then RD_DATA.
REQ-009 In RD_DATA, M_RREADY=1. On M_RVALID the block SHALL register REQ_RDATA=M_RDATA and REQ_RESP=M_RRESP, pulse REQ_DONE[grant] next cycle and return to IDLE.
REQ-010 M_AWADDR, M_WDATA and M_ARADDR SHALL be driven from the latched payload and stay stable while the corresponding VALID is high.
REQ-011 Latency: with zero-wait slave, grant at cycle t SHALL give VALID at t+1, ready-side acceptance at t+2 and REQ_DONE at t+3. The next grant SHALL be possible in the REQ_DONE cycle.
REQ-012 REQ_RDATA SHALL change only on read completion. SLVERR/DECERR responses SHALL be forwarded unchanged, with no retry.
REQ-013 The pointer SHALL update to the served index only on completion.

Reset
REQ-014 While ARESET=1 at a rising edge, the block SHALL force:
  state IDLE, pointer=1;
  all M_*VALID, M_BREADY, M_RREADY, REQ_DONE = 0;
  REQ_RDATA, REQ_RESP, M_AWADDR, M_WDATA, M_ARADDR = 0.
REQ-015 Reset mid-transaction SHALL abandon it with no REQ_DONE. Handshake outputs SHALL be 0 the cycle after reset is sampled.

Verification
REQ-016 The bench SHALL cover these directed scenarios:
  - Write, zero-wait: req0 write addr 4'h4, data 32'hDEADBEEF -> M_AWADDR=4, M_WDATA=DEADBEEF, REQ_DONE=2'b01 exactly once, 3 cycles after grant, REQ_RESP=00.
  - Tie: both request (0: write 4'h0; 1: read 4'h8, slave returns 32'h12345678) -> req0 completes first, then req1 with REQ_RDATA=12345678.
  - Skewed handshake: M_AWREADY on first cycle, M_WREADY 3 cycles later -> M_AWVALID drops after 1 cycle, M_WVALID held 4 cycles, one B handshake.
  - Fairness: both REQ_VALID held high for 4 transactions -> REQ_DONE order 01,10,01,10.
  - Reset mid-read: ARESET in RD_DATA with M_RVALID=0 -> next cycle M_RREADY=0, no REQ_DONE, fresh request granted to req0.
  - Error response: slave M_RRESP=2'b10 -> REQ_RESP=10, REQ_RDATA updated.
